serdes_err_inj: RTL
===================

SERDES_ERR_INJ -- requirements
Module: serdes_err_inj

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, SerDes block payload width.
REQ-002 SHALL have parameter HDR_WIDTH, default 2, sync header width.
REQ-003 SHALL have parameter ARM_COUNT, default 100, clean headers passed before injection starts.
REQ-004 SHALL have parameter TOTAL_HDR, default 500, headers counted in the injection phase before stopping.
REQ-005 SHALL have parameter LFSR_SEED, default 32'h1, nonzero LFSR reset value.
REQ-006 SHALL use one clock; reset is synchronous and active-high.
REQ-007 SHALL have port rx_clk, input, 1, block clock.
REQ-008 SHALL have port rx_rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port in_data, input, DATA_WIDTH, block from the PHY transmit serdes_tx_data.
REQ-010 SHALL have port in_hdr, input, HDR_WIDTH, header from the PHY transmit serdes_tx_hdr.
REQ-011 SHALL have port cfg_enable, input, 1, run the injection sequence.
REQ-012 SHALL have port cfg_threshold, input, 32, error probability scaled by 2^32.
REQ-013 SHALL have port rx_block_lock, input, 1, block lock fed back from the PHY receive path.
REQ-014 SHALL have port out_data, output, DATA_WIDTH, block to the PHY receive serdes_rx_data.
REQ-015 SHALL have port out_hdr, output, HDR_WIDTH, header to the PHY receive serdes_rx_hdr.
REQ-016 SHALL have port count_valid, output, 16, headers passed uncorrupted in INJECT.
REQ-017 SHALL have port count_invalid, output, 16, headers corrupted in INJECT.
REQ-018 SHALL have port lock_lost, output, 1, sticky flag: lock dropped during INJECT.
REQ-019 SHALL have port lock_lost_count, output, 16, count_valid+count_invalid captured at lock loss.
REQ-020 SHALL have port done, output, 1, TOTAL_HDR reached.

Function
REQ-021 SHALL register out_data/out_hdr with exactly one rx_clk of latency from in_data/in_hdr.
REQ-022 SHALL implement FSM states IDLE, WARMUP, INJECT, DONE.
REQ-023 SHALL go IDLE->WARMUP on cfg_enable=1, clearing all counters, lock_lost, lock_lost_count and done in that transition.
REQ-024 SHALL, in WARMUP, pass headers unchanged, count them internally, and enter INJECT after ARM_COUNT headers.
REQ-025 SHALL, in INJECT, output header 2'b11 when the current LFSR value < cfg_threshold and increment count_invalid; otherwise pass in_hdr and increment count_valid.
REQ-026 SHALL advance the 32-bit LFSR every cycle in all states except IDLE; it SHALL never reach zero.
REQ-027 SHALL treat cfg_threshold=0 as never corrupt; cfg_threshold=32'hFFFFFFFF corrupts all except when the LFSR value is 32'hFFFFFFFF.
REQ-028 SHALL, on the first INJECT cycle with rx_block_lock=0, set lock_lost and capture lock_lost_count as count_valid+count_invalid, including the current header; later drops SHALL NOT update it.
REQ-029 SHALL go INJECT->DONE when count_valid+count_invalid reaches TOTAL_HDR, and assert done in that cycle.
REQ-030 SHALL, in DONE, pass headers unchanged and hold all counters and flags until cfg_enable=0.
REQ-031 SHALL return to IDLE from any state when cfg_enable=0; outputs pass through and counters hold their values.
REQ-032 SHALL saturate all 16-bit counters at 16'hFFFF.
REQ-033 SHALL never modify out_data unless SERDES_ERR_INJ_DATA_EN is defined.

Reset
REQ-034 SHALL, on rx_rst, clear out_data, out_hdr, all counters, lock_lost and done, set the LFSR to LFSR_SEED, and enter IDLE.
REQ-035 SHALL have rx_rst mid-INJECT abort the run with no DONE.

Configuration
REQ-036 SHALL, with SERDES_ERR_INJ_DATA_EN defined, invert out_data bit 0 whenever the header is corrupted in INJECT; without it, data SHALL always pass unchanged.

Structure
REQ-037 SHALL place the state enum, INVALID_HDR=2'b11, SYNC_DATA=2'b01, SYNC_CTRL=2'b10 and the LFSR polynomial in serdes_err_inj_pkg.
REQ-038 SHALL implement the LFSR as sub-module err_inj_lfsr (32-bit Galois, seed input, enable input).

Verification
REQ-039 SHALL check cfg_threshold=0, TOTAL_HDR=500 -> count_valid=500, count_invalid=0, lock_lost=0, done=1.
REQ-040 SHALL check cfg_threshold=32'hFFFFFFFF -> lock_lost=1, with lock_lost_count small (<=70 with the PHY attached).
REQ-041 SHALL check cfg_threshold=32'h297F0000 (~0.162) -> count_invalid within 81+/-25 of 500.
REQ-042 SHALL check in_hdr=2'b10 with in_data=64'h0707070707070707 -> identical out_hdr/out_data one cycle later.
REQ-043 SHALL check cfg_enable dropped after 50 INJECT headers -> IDLE with counters held at 50 total; re-enable clears them.
REQ-044 SHALL check rx_rst asserted mid-INJECT -> all outputs zero next cycle, done=0.

Source files
------------

// File: rtl/serdes_err_inj_pkg.sv
// Shared types and constants for the SerDes sync-header error injector.
package serdes_err_inj_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_INJECT,
    ST_DONE
  } state_t;

  localparam logic [1:0]  INVALID_HDR = 2'b11;
  localparam logic [1:0]  SYNC_DATA   = 2'b01;
  localparam logic [1:0]  SYNC_CTRL   = 2'b10;

  // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/serdes_err_inj_lfsr.sv
// 32-bit Galois LFSR with loadable seed and advance enable.
module err_inj_lfsr
  import serdes_err_inj_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic [31:0] i_seed,
  output logic [31:0] o_value
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // A zero seed would lock the register at zero.
      o_value <= (i_seed == '0) ? 32'd1 : i_seed;
    end else if (i_en) begin
      o_value <= o_value[0] ? ((o_value >> 1) ^ LFSR_POLY) : (o_value >> 1);
    end
  end

endmodule

// File: rtl/serdes_err_inj.sv
// Sync-header error injector between PHY TX and RX for block-lock testing.
// Define SERDES_ERR_INJ_DATA_EN to also flip out_data bit 0 on corrupted headers.
module serdes_err_inj
  import serdes_err_inj_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned HDR_WIDTH  = 2,
  parameter int unsigned ARM_COUNT  = 100,
  parameter int unsigned TOTAL_HDR  = 500,
  parameter logic [31:0] LFSR_SEED  = 32'h1
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  input  logic                  cfg_enable,
  input  logic [31:0]           cfg_threshold,
  input  logic                  rx_block_lock,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HDR_WIDTH-1:0]  out_hdr,
  output logic [15:0]           count_valid,
  output logic [15:0]           count_invalid,
  output logic                  lock_lost,
  output logic [15:0]           lock_lost_count,
  output logic                  done
);

  state_t      r_state;
  logic [31:0] r_warm_cnt;
  logic [31:0] w_warm_next;
  logic [31:0] w_lfsr;
  logic        w_lfsr_en;
  logic        w_corrupt;
  logic [16:0] w_total_next;
  logic [15:0] w_total_sat;

  assign w_lfsr_en    = (r_state != ST_IDLE);
  assign w_corrupt    = (r_state == ST_INJECT) && cfg_enable && (w_lfsr < cfg_threshold);
  assign w_warm_next  = r_warm_cnt + 32'd1;
  assign w_total_next = {1'b0, count_valid} + {1'b0, count_invalid} + 17'd1;
  assign w_total_sat  = w_total_next[16] ? 16'hFFFF : w_total_next[15:0];

  err_inj_lfsr u_lfsr (
    .i_clk   (rx_clk),
    .i_rst   (rx_rst),
    .i_en    (w_lfsr_en),
    .i_seed  (LFSR_SEED),
    .o_value (w_lfsr)
  );

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      out_data        <= '0;
      out_hdr         <= '0;
      count_valid     <= '0;
      count_invalid   <= '0;
      lock_lost       <= 1'b0;
      lock_lost_count <= '0;
      done            <= 1'b0;
      r_warm_cnt      <= '0;
      r_state         <= ST_IDLE;
    end else begin
      out_data <= in_data;
      out_hdr  <= w_corrupt ? HDR_WIDTH'(INVALID_HDR) : in_hdr;
`ifdef SERDES_ERR_INJ_DATA_EN
      if (w_corrupt) out_data[0] <= ~in_data[0];
`endif
      if (!cfg_enable) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE: begin
            count_valid     <= '0;
            count_invalid   <= '0;
            lock_lost       <= 1'b0;
            lock_lost_count <= '0;
            done            <= 1'b0;
            r_warm_cnt      <= '0;
            r_state         <= ST_WARMUP;
          end
          ST_WARMUP: begin
            r_warm_cnt <= w_warm_next;
            if (w_warm_next >= ARM_COUNT) r_state <= ST_INJECT;
          end
          ST_INJECT: begin
            if (w_corrupt) count_invalid <= sat_inc16(count_invalid);
            else           count_valid   <= sat_inc16(count_valid);
            // Capture includes the header being counted in this same cycle.
            if (!rx_block_lock && !lock_lost) begin
              lock_lost       <= 1'b1;
              lock_lost_count <= w_total_sat;
            end
            if (w_total_next >= 17'(TOTAL_HDR)) begin
              done    <= 1'b1;
              r_state <= ST_DONE;
            end
          end
          ST_DONE: r_state <= ST_DONE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
